// File: rtl/cpu_pkg.sv
// Shared definitions for the register-file access controller: opcodes,
// controller state encoding and default datapath widths.
package cpu_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 4;
  localparam int OPC_W_DEF  = 3;

  typedef logic [OPC_W_DEF-1:0] opc_t;

  localparam opc_t OP_LOAD = 3'b000;
  localparam opc_t OP_ADD  = 3'b001;
  localparam opc_t OP_ADDI = 3'b010;
  localparam opc_t OP_SUB  = 3'b011;
  localparam opc_t OP_SUBI = 3'b100;
  localparam opc_t OP_MUL  = 3'b101;
  localparam opc_t OP_CLR  = 3'b110;
  localparam opc_t OP_NOP  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_READ  = 2'b01,
    ST_EXEC  = 2'b10,
    ST_WRITE = 2'b11
  } state_e;

endpackage

// File: rtl/rac_alu.sv
// Combinational ALU for the access controller: result, zero and carry/borrow
// from the captured operands and the latched opcode.
module rac_alu
  import cpu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  opc_t              opcode_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [DATA_W-1:0] imm_i,
  output logic [DATA_W-1:0] result_o,
  output logic              zero_o,
  output logic              carry_o
);

  logic [DATA_W-1:0] op2_w;
  logic [DATA_W:0]   sum_w;
  logic [DATA_W:0]   diff_w;
  logic [DATA_W-1:0] prod_w;

  assign op2_w  = (opcode_i == OP_ADDI || opcode_i == OP_SUBI) ? imm_i : b_i;
  assign sum_w  = {1'b0, a_i} + {1'b0, op2_w};
  // Top bit of the widened difference is the borrow, i.e. a < op2 unsigned.
  assign diff_w = {1'b0, a_i} - {1'b0, op2_w};
  assign prod_w = a_i * b_i;

  always_comb begin
    result_o = '0;
    carry_o  = 1'b0;
    case (opcode_i)
      OP_LOAD: result_o = imm_i;
      OP_ADD, OP_ADDI: begin
        result_o = sum_w[DATA_W-1:0];
        carry_o  = sum_w[DATA_W];
      end
      OP_SUB, OP_SUBI: begin
        result_o = diff_w[DATA_W-1:0];
        carry_o  = diff_w[DATA_W];
      end
      OP_MUL:  result_o = prod_w;
      default: result_o = '0;
    endcase
  end

  assign zero_o = (result_o == '0);

endmodule

// File: rtl/regfile_access_ctrl.sv
// Register-file master: accepts one decoded instruction, reads its operands,
// executes it and issues a single write-back, then pulses done.
module regfile_access_ctrl
  import cpu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int OPC_W  = OPC_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [OPC_W-1:0]  opcode,
  input  logic [ADDR_W-1:0] dst,
  input  logic [ADDR_W-1:0] src1,
  input  logic [ADDR_W-1:0] src2,
  input  logic [DATA_W-1:0] imm,
  output logic [ADDR_W-1:0] read_reg_addr_1,
  output logic [ADDR_W-1:0] read_reg_addr_2,
  input  logic [DATA_W-1:0] read_data_1,
  input  logic [DATA_W-1:0] read_data_2,
  output logic              regWrite,
  output logic [ADDR_W-1:0] write_reg_addr,
  output logic [DATA_W-1:0] write_data,
  output logic              done,
  output logic              flag_zero,
  output logic              flag_carry
);

  state_e            state_q, state_d;
  logic [OPC_W-1:0]  opc_q, opc_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [ADDR_W-1:0] src1_q, src1_d;
  logic [ADDR_W-1:0] src2_q, src2_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic [DATA_W-1:0] op_a_q, op_a_d;
  logic [DATA_W-1:0] op_b_q, op_b_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic              reg_write_q, reg_write_d;
  logic              done_q, done_d;
  logic              fz_q, fz_d;
  logic              fc_q, fc_d;

  logic [DATA_W-1:0] alu_res;
  logic              alu_zero;
  logic              alu_carry;

  rac_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .opcode_i (opc_q),
    .a_i      (op_a_q),
    .b_i      (op_b_q),
    .imm_i    (imm_q),
    .result_o (alu_res),
    .zero_o   (alu_zero),
    .carry_o  (alu_carry)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      opc_q       <= '0;
      dst_q       <= '0;
      src1_q      <= '0;
      src2_q      <= '0;
      imm_q       <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      res_q       <= '0;
      waddr_q     <= '0;
      reg_write_q <= 1'b0;
      done_q      <= 1'b0;
      fz_q        <= 1'b0;
      fc_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      opc_q       <= opc_d;
      dst_q       <= dst_d;
      src1_q      <= src1_d;
      src2_q      <= src2_d;
      imm_q       <= imm_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      res_q       <= res_d;
      waddr_q     <= waddr_d;
      reg_write_q <= reg_write_d;
      done_q      <= done_d;
      fz_q        <= fz_d;
      fc_q        <= fc_d;
    end
  end

  // res_q doubles as the write-data register, so it is zero outside WRITE.
  always_comb begin
    state_d     = state_q;
    opc_d       = opc_q;
    dst_d       = dst_q;
    src1_d      = src1_q;
    src2_d      = src2_q;
    imm_d       = imm_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    res_d       = '0;
    waddr_d     = waddr_q;
    reg_write_d = 1'b0;
    done_d      = 1'b0;
    fz_d        = fz_q;
    fc_d        = fc_q;
    unique case (state_q)
      ST_IDLE: begin
        if (instr_valid) begin
          opc_d   = opcode;
          dst_d   = dst;
          src1_d  = src1;
          src2_d  = src2;
          imm_d   = imm;
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        op_a_d  = read_data_1;
        op_b_d  = read_data_2;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        res_d   = alu_res;
        waddr_d = dst_q;
        state_d = ST_WRITE;
        if (opc_q != OP_NOP) begin
          reg_write_d = 1'b1;
          fz_d        = alu_zero;
          fc_d        = alu_carry;
        end
      end
      ST_WRITE: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign instr_ready     = (state_q == ST_IDLE);
  assign read_reg_addr_1 = src1_q;
  assign read_reg_addr_2 = src2_q;
  assign regWrite        = reg_write_q;
  assign write_reg_addr  = waddr_q;
  assign write_data      = res_q;
  assign done            = done_q;
  assign flag_zero       = fz_q;
  assign flag_carry      = fc_q;

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Bench for regfile_access_ctrl: behavioural 16x16 register file plus an
// arithmetic reference model; directed cases followed by random instructions.
module tb_regfile_access_ctrl;

  logic        clock;
  logic        reset;
  logic        instr_valid;
  logic        instr_ready;
  logic [2:0]  opcode;
  logic [3:0]  dst;
  logic [3:0]  src1;
  logic [3:0]  src2;
  logic [15:0] imm;
  logic [3:0]  read_reg_addr_1;
  logic [3:0]  read_reg_addr_2;
  logic [15:0] read_data_1;
  logic [15:0] read_data_2;
  logic        regWrite;
  logic [3:0]  write_reg_addr;
  logic [15:0] write_data;
  logic        done;
  logic        flag_zero;
  logic        flag_carry;

  logic [15:0] rf [16];
  logic        tb_wr;
  logic [3:0]  tb_wa;
  logic [15:0] tb_wd;

  int exp_rf [16];
  int exp_z;
  int exp_c;
  int n_cmp;
  int n_err;

  regfile_access_ctrl dut (
    .clock           (clock),
    .reset           (reset),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .opcode          (opcode),
    .dst             (dst),
    .src1            (src1),
    .src2            (src2),
    .imm             (imm),
    .read_reg_addr_1 (read_reg_addr_1),
    .read_reg_addr_2 (read_reg_addr_2),
    .read_data_1     (read_data_1),
    .read_data_2     (read_data_2),
    .regWrite        (regWrite),
    .write_reg_addr  (write_reg_addr),
    .write_data      (write_data),
    .done            (done),
    .flag_zero       (flag_zero),
    .flag_carry      (flag_carry)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign read_data_1 = rf[read_reg_addr_1];
  assign read_data_2 = rf[read_reg_addr_2];

  always @(posedge clock) begin
    if (regWrite) rf[write_reg_addr] <= write_data;
    else if (tb_wr) rf[tb_wa] <= tb_wd;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference semantics straight from the instruction definitions.
  function automatic void model(input int op, input int a, input int b, input int im,
                                output int res, output int c);
    longint p;
    res = 0;
    c   = 0;
    case (op)
      0: res = im;
      1: begin res = (a + b) % 65536;  c = (a + b >= 65536) ? 1 : 0; end
      2: begin res = (a + im) % 65536; c = (a + im >= 65536) ? 1 : 0; end
      3: begin res = (a - b + 65536) % 65536;  c = (a < b) ? 1 : 0; end
      4: begin res = (a - im + 65536) % 65536; c = (a < im) ? 1 : 0; end
      5: begin p = longint'(a) * longint'(b); res = int'(p % 65536); end
      default: res = 0;
    endcase
  endfunction

  task automatic preset(input int a, input int v);
    tb_wr = 1'b1;
    tb_wa = a[3:0];
    tb_wd = v[15:0];
    @(posedge clock);
    #1 tb_wr = 1'b0;
    exp_rf[a] = v;
    @(negedge clock);
  endtask

  // Called mid-cycle; returns at the negedge of cycle 4 (the done cycle).
  task automatic issue(input int op, input int d, input int s1, input int s2,
                       input int im, input bit hold);
    int res;
    int c;
    int n;
    bit wr;
    n = 0;
    while (!instr_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    check("ready_wait", instr_ready, 1);
    opcode      = op[2:0];
    dst         = d[3:0];
    src1        = s1[3:0];
    src2        = s2[3:0];
    imm         = im[15:0];
    instr_valid = 1'b1;
    model(op, exp_rf[s1], exp_rf[s2], im, res, c);
    wr = (op != 7);
    @(posedge clock);
    #1 if (!hold) instr_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clock);
      check("instr_ready", instr_ready, k == 4);
      check("regWrite", regWrite, (k == 3) && wr);
      check("done", done, k == 4);
      if (k == 1) begin
        check("raddr1", read_reg_addr_1, s1);
        check("raddr2", read_reg_addr_2, s2);
      end
      if (k == 3) begin
        check("waddr", write_reg_addr, d);
        check("wdata", write_data, res);
      end else begin
        check("wdata_idle", write_data, 0);
      end
    end
    if (wr) begin
      exp_rf[d] = res;
      exp_z     = (res == 0) ? 1 : 0;
      exp_c     = c;
    end
    check("rf_dst", rf[d], exp_rf[d]);
    check("flag_zero", flag_zero, exp_z);
    check("flag_carry", flag_carry, exp_c);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected summary");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    exp_z = 0;
    exp_c = 0;
    reset = 1'b0;
    instr_valid = 1'b0;
    opcode = '0; dst = '0; src1 = '0; src2 = '0; imm = '0;
    tb_wr = 1'b0; tb_wa = '0; tb_wd = '0;
    for (int i = 0; i < 16; i++) begin
      rf[i]     = 16'h0;
      exp_rf[i] = 0;
    end

    #1;
    check("rst_ready", instr_ready, 1);
    check("rst_regWrite", regWrite, 0);
    check("rst_done", done, 0);
    check("rst_wdata", write_data, 0);
    check("rst_waddr", write_reg_addr, 0);
    check("rst_raddr1", read_reg_addr_1, 0);
    check("rst_flags", {flag_zero, flag_carry}, 0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("post_rst_ready", instr_ready, 1);

    for (int i = 0; i < 16; i++) preset(i, int'($urandom_range(0, 65535)));

    // 1: LOAD
    issue(0, 3, 0, 0, 16'h00A5, 1'b0);
    check("t1_r3", rf[3], 16'h00A5);
    check("t1_z", flag_zero, 0);

    // 2: ADD with carry out to zero
    preset(1, 16'h7FFF);
    preset(2, 16'h8001);
    issue(1, 4, 1, 2, 0, 1'b0);
    check("t2_r4", rf[4], 16'h0000);
    check("t2_c", flag_carry, 1);
    check("t2_z", flag_zero, 1);

    // 3: SUBI with borrow
    preset(1, 16'h0001);
    issue(4, 5, 1, 0, 16'h0002, 1'b0);
    check("t3_r5", rf[5], 16'hFFFF);
    check("t3_c", flag_carry, 1);
    check("t3_z", flag_zero, 0);

    // 4: MUL truncation, dst == src1
    preset(6, 16'h0100);
    preset(7, 16'h0100);
    issue(5, 6, 6, 7, 0, 1'b0);
    check("t4_r6", rf[6], 16'h0000);
    check("t4_z", flag_zero, 1);
    check("t4_c", flag_carry, 0);

    // 5: reset during READ of an ADD aborts without a write or done
    opcode = 3'b001; dst = 4'd9; src1 = 4'd1; src2 = 4'd2; imm = '0;
    instr_valid = 1'b1;
    @(posedge clock);
    #1 instr_valid = 1'b0;
    @(negedge clock);
    check("t5_in_read", instr_ready, 0);
    reset = 1'b0;
    #1;
    check("t5_rst_ready", instr_ready, 1);
    check("t5_rst_regWrite", regWrite, 0);
    @(negedge clock);
    reset = 1'b1;
    exp_z = 0;
    exp_c = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      check("t5_regWrite", regWrite, 0);
      check("t5_done", done, 0);
      check("t5_ready", instr_ready, 1);
    end
    check("t5_r9", rf[9], exp_rf[9]);
    check("t5_flags", {flag_zero, flag_carry}, 0);

    // 6: valid held high across LOAD then NOP
    issue(0, 2, 0, 0, 5, 1'b1);
    issue(7, 0, 0, 0, 0, 1'b0);
    check("t6_r2", rf[2], 16'h0005);
    check("t6_z", flag_zero, 0);
    check("t6_c", flag_carry, 0);

    // Random instructions, sometimes back-to-back with valid held high
    for (int i = 0; i < 40; i++) begin
      issue(int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
            int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
            int'($urandom_range(0, 65535)), bit'($urandom_range(0, 1)));
    end
    instr_valid = 1'b0;
    repeat (2) @(negedge clock);
    for (int i = 0; i < 16; i++) check("final_rf", rf[i], exp_rf[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
